// File: rtl/auto_count_pkg.sv
// auto_count_pkg: shared state and mode encodings for the two-digit BCD auto counter
package auto_count_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
  typedef enum logic [1:0] {MODE_UP, MODE_DOWN, MODE_PINGPONG, MODE_ONCE} mode_t;
  localparam logic [3:0] BCD_MAX = 4'd9;
endpackage

// File: rtl/auto_count_ctrl_if.sv
// auto_count_ctrl_if: controller <-> buttons and cascaded digit counters
interface auto_count_ctrl_if;
  logic       run_btn;
  logic       clear_btn;
  logic [1:0] mode;
  logic [3:0] ones_q;
  logic [3:0] tens_q;
  logic       cnt_reset;
  logic       ones_en;
  logic       tens_en;
  logic       up_down;
  logic [3:0] ones_max;
  logic [3:0] tens_max;
  logic       tick;
  logic       running;
  logic       done;
  modport master (
    input  run_btn, clear_btn, mode, ones_q, tens_q,
    output cnt_reset, ones_en, tens_en, up_down, ones_max, tens_max, tick, running, done
  );
  modport slave (
    output run_btn, clear_btn, mode, ones_q, tens_q,
    input  cnt_reset, ones_en, tens_en, up_down, ones_max, tens_max, tick, running, done
  );
endinterface

// File: rtl/tick_prescaler.sv
// tick_prescaler: registered one-cycle strobe every TICK_DIV enabled cycles
module tick_prescaler #(
  parameter int TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int W = $clog2(TICK_DIV);
  logic [W-1:0] cnt;
  logic         wrap;
  assign wrap = cnt == W'(TICK_DIV - 1);
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= en && wrap;
      if (en) cnt <= wrap ? '0 : cnt + 1'b1;
    end
  end
endmodule

// File: rtl/auto_count_ctrl.sv
// auto_count_ctrl: sequences cascaded ones/tens up-down counters as a BCD counter over 00..LIMIT
module auto_count_ctrl
  import auto_count_pkg::*;
#(
  parameter int TICK_DIV   = 50000000,
  parameter int LIMIT_TENS = 3,
  parameter int LIMIT_ONES = 1
) (
  input logic clk,
  input logic reset,
  auto_count_ctrl_if.master bus
);
  localparam logic [3:0] LT = 4'(LIMIT_TENS);
  localparam logic [3:0] LO = 4'(LIMIT_ONES);
  state_t     state, state_nx;
  mode_t      mode_r;
  logic       dir, dir_eff, step, tick, carry, land_top, at_top, at_zero, cnt_reset;
  logic [3:0] tn, ones_max, ones_inc, tens_inc;
  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_ps (
    .clk,
    .reset,
    .en  (state == RUN),
    .clr (bus.clear_btn || state == IDLE || state == DONE),
    .tick
  );
  assign at_top   = bus.tens_q == LT && bus.ones_q == LO;
  assign at_zero  = bus.tens_q == 4'd0 && bus.ones_q == 4'd0;
  assign dir_eff  = (mode_r == MODE_PINGPONG && (dir ? at_top : at_zero)) ? !dir : dir;
  assign tn       = bus.tens_q == 4'd0 ? LT : bus.tens_q - 4'd1;
  assign ones_max = ((dir_eff ? bus.tens_q : tn) == LT) ? LO : BCD_MAX;
  assign step     = tick && state == RUN && !bus.clear_btn;
  assign carry    = dir_eff ? bus.ones_q == ones_max : bus.ones_q == 4'd0;
  // next value when counting up, used to stop on the limit in up-once mode
  assign ones_inc = bus.ones_q == ones_max ? 4'd0 : bus.ones_q + 4'd1;
  assign tens_inc = carry ? (bus.tens_q == LT ? 4'd0 : bus.tens_q + 4'd1) : bus.tens_q;
  assign land_top = ones_inc == LO && tens_inc == LT;
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      dir       <= 1'b1;
      mode_r    <= MODE_UP;
      cnt_reset <= 1'b1;
    end else begin
      state     <= state_nx;
      cnt_reset <= bus.clear_btn || (state == DONE && bus.run_btn);
      if (state == IDLE) mode_r <= mode_t'(bus.mode);
      if (bus.clear_btn) dir <= mode_r != MODE_DOWN;
      else if (state == IDLE && bus.run_btn) dir <= bus.mode != MODE_DOWN;
      else if (step) dir <= dir_eff;
    end
  end
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = bus.run_btn ? RUN : IDLE;
      RUN:     state_nx = bus.run_btn ? PAUSE : (step && mode_r == MODE_ONCE && land_top) ? DONE : RUN;
      PAUSE:   state_nx = bus.run_btn ? RUN : PAUSE;
      DONE:    state_nx = bus.run_btn ? RUN : DONE;
      default: state_nx = IDLE;
    endcase
    if (bus.clear_btn) state_nx = state == DONE ? IDLE : state;
  end
  always_comb begin
    bus.cnt_reset = cnt_reset;
    bus.ones_en   = step;
    bus.tens_en   = step && carry;
    bus.up_down   = dir_eff;
    bus.ones_max  = ones_max;
    bus.tens_max  = LT;
    bus.tick      = tick;
    bus.running   = state == RUN;
    bus.done      = state == DONE;
  end
endmodule

// File: tb/tb_auto_count_ctrl.sv
// tb_auto_count_ctrl: controller plus behavioural digit counters, table vectors, corner sequences, random vs model
module tb_auto_count_ctrl;
  localparam int L = 31;
  localparam int D = 4;
  bit clk = 0;
  logic rst, run, clr;
  logic [1:0] mode;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  auto_count_ctrl_if bus();
  assign bus.run_btn   = run;
  assign bus.clear_btn = clr;
  assign bus.mode      = mode;
  auto_count_ctrl #(.TICK_DIV(D), .LIMIT_TENS(3), .LIMIT_ONES(1)) dut (.clk(clk), .reset(rst), .bus(bus));
  function automatic logic [3:0] nxt_digit(logic [3:0] q, logic [3:0] m, logic up);
    return up ? (q == m ? 4'd0 : q + 4'd1) : (q == 4'd0 ? m : q - 4'd1);
  endfunction
  always_ff @(posedge clk) begin
    if (bus.cnt_reset) begin
      bus.ones_q <= 4'd0;
      bus.tens_q <= 4'd0;
    end else begin
      if (bus.ones_en) bus.ones_q <= nxt_digit(bus.ones_q, bus.ones_max, bus.up_down);
      if (bus.tens_en) bus.tens_q <= nxt_digit(bus.tens_q, bus.tens_max, bus.up_down);
    end
  end
  function automatic int cnt_val();
    return int'(bus.tens_q) * 10 + int'(bus.ones_q);
  endfunction
  task automatic check(string name, int got, int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
    end
  endtask
  task automatic timeout(string name);
    total++;
    bad++;
    $display("FAIL %s got=no_tick exp=tick at %0t", name, $time);
  endtask
  task automatic clk1();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_tick(output bit ok);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.tick) begin
        ok = 1;
        return;
      end
      clk1();
    end
  endtask
  task automatic do_reset();
    rst = 1;
    repeat (3) clk1();
    rst = 0;
    clk1();
  endtask
  task automatic steps(int n);
    bit ok;
    for (int i = 0; i < n; i++) begin
      wait_tick(ok);
      if (!ok) begin
        timeout("step_wait");
        return;
      end
      clk1();
    end
  endtask
  // reference model: integer count value, abstract state number, prescaler phase
  int ms, mph, mmode, mv;
  bit mtick, mdir, mcrst;
  task automatic mcyc();
    bit de, stp;
    int nxt, ns;
    #1;
    de  = (mmode == 2 && (mdir ? mv == L : mv == 0)) ? !mdir : mdir;
    stp = mtick && ms == 1 && !clr;
    nxt = de ? (mv == L ? 0 : mv + 1) : (mv == 0 ? L : mv - 1);
    check("rnd_up_down", bus.up_down, de);
    check("rnd_ones_en", bus.ones_en, stp);
    check("rnd_tens_en", bus.tens_en, stp && (nxt / 10 != mv / 10));
    @(posedge clk);
    #1;
    mv = mcrst ? 0 : stp ? nxt : mv;
    if (rst) begin
      ms = 0; mph = 0; mtick = 0; mdir = 1; mmode = 0; mcrst = 1;
    end else begin
      ns = ms;
      if (clr) ns = (ms == 3) ? 0 : ms;
      else if (run) ns = (ms == 1) ? 2 : 1;
      else if (ms == 1 && stp && mmode == 3 && nxt == L) ns = 3;
      mcrst = clr || (ms == 3 && run);
      if (clr) mdir = mmode != 1;
      else if (ms == 0 && run) mdir = mode != 2'd1;
      else if (stp) mdir = de;
      if (clr || ms == 0 || ms == 3) begin
        mph = 0; mtick = 0;
      end else if (ms == 1) begin
        mtick = mph == D - 1; mph = (mph + 1) % D;
      end else mtick = 0;
      if (ms == 0) mmode = int'(mode);
      ms = ns;
    end
    check("rnd_count", cnt_val(), mv);
    check("rnd_running", bus.running, ms == 1);
    check("rnd_done", bus.done, ms == 3);
    check("rnd_tick", bus.tick, mtick);
    check("rnd_cnt_reset", bus.cnt_reset, mcrst);
  endtask
  typedef struct {
    logic [1:0] mode;
    int steps;
    int last;
    int carries;
    int carry_sum;
    int downs;
    bit done;
  } vec_t;
  vec_t vecs[4];
  initial begin
    bit ok, en_seen, held;
    int lat, carries, csum, downs;
    vecs[0] = '{2'd0, 33, 1, 4, 88, 0, 1'b0};
    vecs[1] = '{2'd1, 33, 31, 5, 60, 33, 1'b0};
    vecs[2] = '{2'd2, 64, 2, 6, 117, 31, 1'b0};
    vecs[3] = '{2'd3, 31, 31, 3, 57, 0, 1'b1};
    rst = 1; run = 0; clr = 0; mode = 2'd0;
    clk1();
    check("rst_cnt_reset", bus.cnt_reset, 1);
    check("rst_tick", bus.tick, 0);
    check("rst_running", bus.running, 0);
    check("rst_done", bus.done, 0);
    clk1(); clk1();
    check("rst_cnt_reset_held", bus.cnt_reset, 1);
    rst = 0;
    clk1();
    check("rst_release_cnt_reset", bus.cnt_reset, 0);
    check("rst_count", cnt_val(), 0);
    for (int e = 0; e < 4; e++) begin
      do_reset();
      mode = vecs[e].mode;
      clk1();
      run = 1; clk1(); run = 0;
      lat = 0;
      while (!bus.tick && lat < 20) begin
        clk1();
        lat++;
      end
      check("first_tick_latency", lat, D);
      carries = 0; csum = 0; downs = 0;
      for (int s = 0; s < vecs[e].steps; s++) begin
        wait_tick(ok);
        if (!ok) begin
          timeout("vec_step");
          break;
        end
        check("vec_ones_en", bus.ones_en, 1);
        if (bus.tens_en) begin
          carries++;
          csum += cnt_val();
        end
        if (!bus.up_down) downs++;
        clk1();
      end
      check("vec_last", cnt_val(), vecs[e].last);
      check("vec_carries", carries, vecs[e].carries);
      check("vec_carry_sum", csum, vecs[e].carry_sum);
      check("vec_downs", downs, vecs[e].downs);
      check("vec_done", bus.done, vecs[e].done);
    end
    en_seen = 0;
    repeat (12) begin
      clk1();
      en_seen |= bus.ones_en | bus.tens_en;
    end
    check("done_no_enable", en_seen, 0);
    check("done_hold_value", cnt_val(), 31);
    check("done_flag", bus.done, 1);
    run = 1; clk1(); run = 0;
    check("restart_cnt_reset", bus.cnt_reset, 1);
    check("restart_running", bus.running, 1);
    check("restart_done", bus.done, 0);
    clk1();
    check("restart_count", cnt_val(), 0);
    check("restart_cnt_reset_drop", bus.cnt_reset, 0);
    steps(1);
    check("restart_first_step", cnt_val(), 1);
    do_reset();
    mode = 2'd0;
    clk1();
    run = 1; clk1(); run = 0;
    steps(17);
    check("pause_start", cnt_val(), 17);
    run = 1; clk1(); run = 0;
    check("pause_running", bus.running, 0);
    held = 1;
    repeat (20) begin
      clk1();
      held &= (cnt_val() == 17) && !bus.tick;
    end
    check("pause_hold", held, 1);
    run = 1; clk1(); run = 0;
    lat = 0;
    while (!bus.tick && lat < 20) begin
      clk1();
      lat++;
    end
    check("resume_phase", lat, 2);
    clk1();
    check("resume_count", cnt_val(), 18);
    steps(7);
    check("pre_clear_count", cnt_val(), 25);
    wait_tick(ok);
    if (!ok) timeout("clear_tick_wait");
    clr = 1; run = 1; clk1(); clr = 0; run = 0;
    check("clear_no_step", cnt_val(), 25);
    check("clear_running", bus.running, 1);
    check("clear_cnt_reset", bus.cnt_reset, 1);
    clk1();
    check("clear_count_zero", cnt_val(), 0);
    rst = 1; clk1();
    check("midrun_reset_running", bus.running, 0);
    check("midrun_reset_cnt_reset", bus.cnt_reset, 1);
    repeat (2) clk1();
    ms = 0; mph = 0; mtick = 0; mdir = 1; mmode = 0; mcrst = 1; mv = 0;
    rst = 0;
    for (int i = 0; i < 3000; i++) begin
      rst = $urandom_range(0, 499) == 0;
      run = $urandom_range(0, 39) == 0;
      clr = $urandom_range(0, 149) == 0;
      if ($urandom_range(0, 59) == 0) mode = 2'($urandom_range(0, 3));
      mcyc();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
